issue_queue_ctrl: RTL and testbench
===================================

Name: issue_queue_ctrl

Overview:
- Decoupling buffer and dual-issue scheduler between decode and execute in the dual-issue MIPS pipeline.
- Accepts up to two decoded instructions per cycle into a circular queue.
- Each cycle, selects zero, one or two oldest entries for issue, applying pairing rules: intra-pair RAW/WAW hazards, single memory port, branch/delay-slot pairing and privileged single-issue.
- Flushed on redirect from execute.

Parameters:
- DEPTH, 8, queue entries; must be a power of two, ≥4.
- PAYLOAD_W, 128, opaque decoded-instruction bits carried through unchanged (pc, imm, ctl, etc.).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline redirect; empties queue.
- in_valid  in  2  lane 1 = older instruction, lane 0 = younger; lane 0 valid without lane 1 is illegal.
- in_payload  in  2×PAYLOAD_W  decoded payload per lane.
- in_ra1, in_ra2, in_rdst  in  2×5 each  source/dest register per lane; 0 means none.
- in_is_br  in  2  branch/jump (has delay slot).
- in_is_mem  in  2  load/store.
- in_is_priv  in  2  cp0/eret/syscall/break; must issue alone.
- in_ready  out  1  high when free entries ≥ 2.
- out_valid  out  2  lane 1 = older issued, lane 0 = younger issued.
- out_payload  out  2×PAYLOAD_W  issued payloads.
- out_ready  in  1  execute accepts this cycle; 0 = stall.
- count  out  $clog2(DEPTH)+1  occupied entries.
- dual_cnt  out  32  performance counter of dual-issue cycles.

Behaviour:
- Reset (resetn low, asynchronous):
  - head = tail = count = 0; dual_cnt = 0.
  - out_valid = 0; in_ready = 1.
  - Payload storage is not reset.
- Enqueue when in_ready & in_valid[1] & ~flush:
  - Lane 1 is written at tail; lane 0, if valid, at tail+1.
  - tail advances by popcount(in_valid).
  - Inputs are ignored when in_ready = 0; upstream holds them.
- Issue is combinational from queue state; H = entry at head, S = entry at head+1.
  - out_valid[1] = (count ≥ 1) & ~(H.is_br & count < 2). A branch never issues without its delay slot.
  - out_valid[0] = out_valid[1] & count ≥ 2 & pair_ok.
  - pair_ok requires all of:
    - S.is_br = 0;
    - H.is_priv = 0 and S.is_priv = 0;
    - not (H.is_mem & S.is_mem);
    - H.rdst = 0 or H.rdst ∉ {S.ra1, S.ra2, S.rdst}.
  - Exception: if H.is_br, the pair issues regardless of the RAW/WAW/mem rules, except priv. If H.is_br and S is priv, out_valid = 0 (branch stalls until flushed); this combination is illegal upstream.
- Dequeue: when out_ready = 1, head advances by popcount(out_valid). When out_ready = 0, head is unchanged and outputs stay stable.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq − deq.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full = count == DEPTH.
- Flush:
  - Takes effect at the next edge: head = tail, count = 0.
  - Same-cycle enqueue is dropped.
  - Same-cycle issue is still presented; the consumer discards it on flush.
  - dual_cnt is not cleared.
- dual_cnt increments when out_ready & out_valid == 2'b11 & ~flush. It saturates at 2^32−1.
- Latency: an instruction enqueued at edge N is visible on out_* in cycle N+1 (combinational read).

Decomposition:
- Shared package (cpu_pkg):
  - typedef iq_entry_t {payload, ra1, ra2, rdst, is_br, is_mem, is_priv}.
  - creg_addr_t (5-bit).
  - IQ_DEPTH constant.
- One sub-module, iq_pair_check: purely combinational pair_ok and branch-slot logic over two iq_entry_t. It is unit-testable in isolation.
- Storage array and pointers live in the top.

Test Plan:
- Reset mid-operation: fill 3 entries, pulse resetn low asynchronously → count = 0, out_valid = 0, in_ready = 1 immediately, without waiting for a clk edge.
- Independent pair: addu r3←r1,r2 then addu r5←r4,r4, out_ready = 1 → out_valid = 11 the cycle after enqueue, dual_cnt = 1, count = 0.
- RAW: addu r3←r1,r2 then subu r6←r3,r7 → cycle 1 out_valid = 10 (addu); cycle 2 out_valid = 10 (subu); dual_cnt = 0.
- Branch alone: enqueue beq with in_valid = 10 → out_valid = 00. Next cycle enqueue its delay slot (sw) → out_valid = 11 with beq on lane 1.
- Full/wrap: out_ready = 0, enqueue 4 pairs (DEPTH = 8) → count = 8, in_ready = 0, further enqueue ignored. Then out_ready = 1 with 8 independent ALU ops → four dual issues, head wraps to 0, and the next enqueue lands at entry 0.
- Flush collision: count = 4 and flush = 1 with in_valid = 11 in the same cycle → next cycle count = 0, out_valid = 00, dual_cnt unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the dual-issue pipeline front end.
// Issue-queue entry layout and sizing constants.
package cpu_pkg;

  localparam int IQ_DEPTH     = 8;
  localparam int IQ_PAYLOAD_W = 128;

  typedef logic [4:0] creg_addr_t;

  typedef struct packed {
    logic [IQ_PAYLOAD_W-1:0] payload;
    creg_addr_t              ra1;
    creg_addr_t              ra2;
    creg_addr_t              rdst;
    logic                    is_br;
    logic                    is_mem;
    logic                    is_priv;
  } iq_entry_t;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/iq_pair_check.sv
// Pairing rules for the two oldest queue entries.
// Pure combinational: decides how many of head/head+1 may issue.
module iq_pair_check
  import cpu_pkg::*;
(
  input  iq_entry_t  h,
  input  iq_entry_t  s,
  input  logic       avail1,
  input  logic       avail2,
  output logic [1:0] issue
);

  logic reg_hit;
  logic mem_hit;
  logic pair_ok;
  logic br_stall;
  logic unused_payload;

  assign unused_payload = ^{h.payload, s.payload};

  assign reg_hit = (h.rdst != '0) &&
                   ((h.rdst == s.ra1) ||
                    (h.rdst == s.ra2) ||
                    (h.rdst == s.rdst));

  assign mem_hit = h.is_mem & s.is_mem;

  // A branch drags its delay slot along regardless of data hazards.
  assign pair_ok = ~s.is_br & ~h.is_priv & ~s.is_priv &
                   (h.is_br | (~mem_hit & ~reg_hit));

  assign br_stall = h.is_br & (~avail2 | s.is_priv);

  always_comb begin
    issue    = 2'b00;
    issue[1] = avail1 & ~br_stall;
    issue[0] = issue[1] & avail2 & pair_ok;
  end

endmodule

// File: rtl/issue_queue_ctrl.sv
// Decode-to-execute issue queue with dual-issue scheduling.
// Circular buffer; head pair is read combinationally.
module issue_queue_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic [1:0]                  in_valid,
  input  logic [1:0][PAYLOAD_W-1:0]   in_payload,
  input  creg_addr_t [1:0]            in_ra1,
  input  creg_addr_t [1:0]            in_ra2,
  input  creg_addr_t [1:0]            in_rdst,
  input  logic [1:0]                  in_is_br,
  input  logic [1:0]                  in_is_mem,
  input  logic [1:0]                  in_is_priv,
  output logic                        in_ready,
  output logic [1:0]                  out_valid,
  output logic [1:0][PAYLOAD_W-1:0]   out_payload,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic [31:0]                 dual_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  iq_entry_t        mem_q [DEPTH];
  iq_entry_t [1:0]  in_ent;
  iq_entry_t        h_ent;
  iq_entry_t        s_ent;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;

  logic          enq;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;
  logic [CW-1:0] count_next;

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  assign in_ready = count <= CW'(DEPTH - 2);
  assign enq      = in_ready & in_valid[1] & ~flush;
  assign enq_n    = enq ? pop2(in_valid) : 2'd0;
  assign deq_n    = out_ready ? pop2(out_valid) : 2'd0;

  assign count_next = count + CW'(enq_n) - CW'(deq_n);

  always_comb begin
    in_ent = '0;
    for (int l = 0; l < 2; l++) begin
      in_ent[l].payload = in_payload[l];
      in_ent[l].ra1     = in_ra1[l];
      in_ent[l].ra2     = in_ra2[l];
      in_ent[l].rdst    = in_rdst[l];
      in_ent[l].is_br   = in_is_br[l];
      in_ent[l].is_mem  = in_is_mem[l];
      in_ent[l].is_priv = in_is_priv[l];
    end
  end

  assign h_ent = mem_q[head];
  assign s_ent = mem_q[head_p1];

  iq_pair_check u_pair (
    .h      (h_ent),
    .s      (s_ent),
    .avail1 (count >= CW'(1)),
    .avail2 (count >= CW'(2)),
    .issue  (out_valid)
  );

  assign out_payload[1] = h_ent.payload;
  assign out_payload[0] = s_ent.payload;

  // Payload storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail] <= in_ent[1];
      if (in_valid[0]) mem_q[tail_p1] <= in_ent[0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq_n);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dual_cnt <= '0;
    end else if (out_ready & (&out_valid) & ~flush & ~(&dual_cnt)) begin
      dual_cnt <= dual_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Scoreboard bench for issue_queue_ctrl: directed scenarios then
// random traffic checked against a queue-based reference model.
module tb_issue_queue_ctrl;

  localparam int DEPTH = 8;
  localparam int PW    = 128;

  typedef struct {
    logic [PW-1:0] p;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic [4:0]    rd;
    bit            br;
    bit            mem;
    bit            priv;
  } ins_t;

  typedef struct {
    logic [1:0]    mask;
    logic [PW-1:0] p1;
    logic [PW-1:0] p0;
    int            cnt;
    bit            rdy;
    logic [31:0]   dual;
  } exp_t;

  logic                   clk = 0;
  logic                   resetn = 0;
  logic                   flush = 0;
  logic [1:0]             in_valid = 0;
  logic [1:0][PW-1:0]     in_payload = '0;
  logic [1:0][4:0]        in_ra1 = '0;
  logic [1:0][4:0]        in_ra2 = '0;
  logic [1:0][4:0]        in_rdst = '0;
  logic [1:0]             in_is_br = 0;
  logic [1:0]             in_is_mem = 0;
  logic [1:0]             in_is_priv = 0;
  logic                   in_ready;
  logic [1:0]             out_valid;
  logic [1:0][PW-1:0]     out_payload;
  logic                   out_ready = 0;
  logic [3:0]             count;
  logic [31:0]            dual_cnt;

  issue_queue_ctrl #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_payload  (in_payload),
    .in_ra1      (in_ra1),
    .in_ra2      (in_ra2),
    .in_rdst     (in_rdst),
    .in_is_br    (in_is_br),
    .in_is_mem   (in_is_mem),
    .in_is_priv  (in_is_priv),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .out_ready   (out_ready),
    .count       (count),
    .dual_cnt    (dual_cnt)
  );

  always #5 clk = ~clk;

  ins_t        mq[$];
  exp_t        exp_q[$];
  logic [31:0] mdual = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  ins_t        nop = '{default: 0};

  task automatic chk(input string name, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue rules stated over the instruction list, oldest first.
  function automatic logic [1:0] model_mask();
    ins_t h, s;
    if (mq.size() == 0) return 2'b00;
    h = mq[0];
    if (h.br) begin
      if (mq.size() < 2) return 2'b00;
      s = mq[1];
      if (s.priv) return 2'b00;
      if (s.br) return 2'b10;
      return 2'b11;
    end
    if (mq.size() < 2) return 2'b10;
    s = mq[1];
    if (h.priv || s.priv || s.br) return 2'b10;
    if (h.mem && s.mem) return 2'b10;
    if (h.rd != 0 && (h.rd == s.ra1 || h.rd == s.ra2 || h.rd == s.rd))
      return 2'b10;
    return 2'b11;
  endfunction

  function automatic ins_t mk(input int rd, input int a1, input int a2,
                              input bit br, input bit mem, input bit priv);
    ins_t i;
    i.p    = {$urandom(), $urandom(), $urandom(), $urandom()};
    i.rd   = 5'(rd);
    i.ra1  = 5'(a1);
    i.ra2  = 5'(a2);
    i.br   = br;
    i.mem  = mem;
    i.priv = priv;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    bit br;
    br = ($urandom_range(0, 5) == 0);
    return mk($urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), br,
              !br && ($urandom_range(0, 2) == 0),
              !br && ($urandom_range(0, 11) == 0));
  endfunction

  task automatic step(input logic [1:0] iv, input ins_t a, input ins_t b,
                      input bit rdy, input bit fl);
    exp_t e;
    bit   enq;
    int   nd;
    @(negedge clk);
    in_valid      = iv;
    in_payload[1] = a.p;   in_payload[0] = b.p;
    in_ra1        = {a.ra1, b.ra1};
    in_ra2        = {a.ra2, b.ra2};
    in_rdst       = {a.rd, b.rd};
    in_is_br      = {a.br, b.br};
    in_is_mem     = {a.mem, b.mem};
    in_is_priv    = {a.priv, b.priv};
    out_ready     = rdy;
    flush         = fl;
    e.mask = model_mask();
    e.p1   = mq.size() > 0 ? mq[0].p : '0;
    e.p0   = mq.size() > 1 ? mq[1].p : '0;
    e.cnt  = mq.size();
    e.rdy  = (DEPTH - mq.size()) >= 2;
    e.dual = mdual;
    exp_q.push_back(e);
    enq = e.rdy && iv[1] && !fl;
    nd  = rdy ? (int'(e.mask[1]) + int'(e.mask[0])) : 0;
    if (rdy && e.mask == 2'b11 && !fl && mdual != 32'hffff_ffff)
      mdual++;
    if (fl) mq.delete();
    else begin
      repeat (nd) void'(mq.pop_front());
      if (enq) begin
        mq.push_back(a);
        if (iv[0]) mq.push_back(b);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid", PW'(out_valid), PW'(e.mask));
        chk("count", PW'(count), PW'(e.cnt));
        chk("in_ready", PW'(in_ready), PW'(e.rdy));
        chk("dual_cnt", PW'(dual_cnt), PW'(e.dual));
        if (e.mask[1]) chk("payload1", out_payload[1], e.p1);
        if (e.mask[0]) chk("payload0", out_payload[0], e.p0);
      end
    end
  end

  initial begin : stim
    ins_t a, b;
    bit   r;
    #12 resetn = 1;
    step(2'b00, nop, nop, 1, 0);

    // Asynchronous reset while three entries are held.
    step(2'b11, mk(1, 0, 0, 0, 0, 0), mk(2, 0, 0, 0, 0, 0), 0, 0);
    step(2'b10, mk(3, 0, 0, 0, 0, 0), nop, 0, 0);
    step(2'b00, nop, nop, 0, 0);
    #3;
    in_valid = 0;
    resetn   = 0;
    #1;
    chk("rst_count", PW'(count), PW'(0));
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    mq.delete();
    mdual = 0;
    #1 resetn = 1;

    // Fill to full, try one more pair, then drain with wraparound.
    for (int i = 0; i < 4; i++)
      step(2'b11, mk(2*i+1, 0, 0, 0, 0, 0), mk(2*i+2, 0, 0, 0, 0, 0), 0, 0);
    step(2'b11, mk(20, 0, 0, 0, 0, 0), mk(21, 0, 0, 0, 0, 0), 0, 0);
    for (int i = 0; i < 4; i++) step(2'b00, nop, nop, 1, 0);
    step(2'b11, mk(9, 0, 0, 0, 0, 0), mk(10, 0, 0, 0, 0, 0), 1, 0);
    step(2'b00, nop, nop, 1, 0);
    step(2'b00, nop, nop, 1, 0);

    // Independent pair.
    step(2'b11, mk(3, 1, 2, 0, 0, 0), mk(5, 4, 4, 0, 0, 0), 1, 0);
    step(2'b00, nop, nop, 1, 0);
    step(2'b00, nop, nop, 1, 0);

    // RAW pair splits.
    step(2'b11, mk(3, 1, 2, 0, 0, 0), mk(6, 3, 7, 0, 0, 0), 1, 0);
    step(2'b00, nop, nop, 1, 0);
    step(2'b00, nop, nop, 1, 0);
    step(2'b00, nop, nop, 1, 0);

    // Branch waits for its delay slot.
    step(2'b10, mk(0, 1, 2, 1, 0, 0), nop, 1, 0);
    step(2'b10, mk(0, 3, 4, 0, 1, 0), nop, 1, 0);
    step(2'b00, nop, nop, 1, 0);
    step(2'b00, nop, nop, 1, 0);

    // Flush colliding with an enqueue.
    step(2'b11, mk(1, 0, 0, 0, 0, 0), mk(2, 0, 0, 0, 0, 0), 0, 0);
    step(2'b11, mk(3, 0, 0, 0, 0, 0), mk(4, 0, 0, 0, 0, 0), 0, 0);
    step(2'b11, mk(5, 0, 0, 0, 0, 0), mk(6, 0, 0, 0, 0, 0), 1, 1);
    step(2'b00, nop, nop, 1, 0);
    step(2'b00, nop, nop, 1, 0);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      int k;
      a = rnd_ins();
      b = rnd_ins();
      k = $urandom_range(0, 3);
      r = ($urandom_range(0, 3) != 0);
      step(k == 0 ? 2'b00 : (k == 1 ? 2'b10 : 2'b11), a, b, r,
           $urandom_range(0, 19) == 0);
    end
    step(2'b00, nop, nop, 1, 0);
    @(negedge clk);
    #4;
    chk("scoreboard_drained", PW'(exp_q.size()), PW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
